// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter state encoding and divisor clamping.
package uart_tx_dev_pkg;

   localparam logic [1:0] UART_DATA   = 2'd0;
   localparam logic [1:0] UART_STATUS = 2'd1;
   localparam logic [1:0] UART_DIV    = 2'd2;

   localparam int ST_BUSY_BIT  = 0;
   localparam int ST_FULL_BIT  = 1;
   localparam int ST_EMPTY_BIT = 2;
   localparam int ST_OVF_BIT   = 3;
   localparam int ST_IE_BIT    = 4;

   localparam logic [15:0] MIN_DIV = 16'd2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   // Bit periods shorter than two cycles cannot be counted down, so clamp.
   function automatic logic [15:0] clamp_div(input logic [15:0] d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; a push while full is accepted only when a pop
// frees the head entry in the same cycle, otherwise it is flagged as overflow.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             sys_rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign overflow = push && full && !do_pop;
   assign rd_data  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_dev.sv
// UART transmitter peripheral: CPU-written bytes are queued and sent as 8N1
// frames, LSB first; irq signals that the queue has fully drained.
module uart_tx_dev
   import uart_tx_dev_pkg::*;
#(
   parameter int BAUD_DIV   = 87,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk_in,
   input  logic        sys_rstn,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        uart_txd,
   output logic        irq
);

   tx_state_e   state;
   logic [15:0] div_q;
   logic [15:0] frame_div;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_q;
   logic        txd_q;
   logic        irq_q;
   logic        ie_q;
   logic        ovf_q;

   logic        fifo_push;
   logic        fifo_pop;
   logic [7:0]  fifo_rd;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_ovf;
   logic        busy;
   logic        bit_end;
   logic        unused_wdata;

   assign fifo_push    = we && (addr == UART_DATA);
   assign fifo_pop     = (state == TX_IDLE) && !fifo_empty;
   assign busy         = (state != TX_IDLE);
   assign bit_end      = (cnt == '0);
   assign uart_txd     = txd_q;
   assign irq          = irq_q;
   assign unused_wdata = ^wdata[31:16];

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_in   (clk_in),
      .sys_rstn (sys_rstn),
      .push     (fifo_push),
      .wr_data  (wdata[7:0]),
      .pop      (fifo_pop),
      .rd_data  (fifo_rd),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (fifo_ovf)
   );

   // The divisor is latched per frame so DIVISOR writes only affect later frames.
   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state     <= TX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         frame_div <= 16'(BAUD_DIV);
         txd_q     <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               txd_q <= 1'b1;
               if (!fifo_empty) begin
                  state     <= TX_START;
                  frame_div <= div_q;
                  cnt       <= div_q - 16'd1;
                  txd_q     <= 1'b0;
               end
            end
            TX_START: begin
               if (bit_end) begin
                  state   <= TX_DATA;
                  cnt     <= frame_div - 16'd1;
                  bit_idx <= '0;
                  txd_q   <= shift_q[0];
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            TX_DATA: begin
               if (bit_end) begin
                  cnt <= frame_div - 16'd1;
                  if (bit_idx == 3'd7) begin
                     state <= TX_STOP;
                     txd_q <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd_q   <= shift_q[1];
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            TX_STOP: begin
               if (bit_end) state <= TX_IDLE;
               else         cnt   <= cnt - 16'd1;
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (fifo_pop)                      shift_q <= fifo_rd;
      else if ((state == TX_DATA) && bit_end) shift_q <= {1'b0, shift_q[7:1]};
   end

   always_ff @(posedge clk_in or negedge sys_rstn) begin
      if (!sys_rstn) begin
         div_q <= 16'(BAUD_DIV);
         ie_q  <= 1'b0;
         ovf_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (we && (addr == UART_DIV)) div_q <= clamp_div(wdata[15:0]);
         if (we && (addr == UART_STATUS)) begin
            ie_q <= wdata[ST_IE_BIT];
            if (wdata[ST_OVF_BIT]) ovf_q <= 1'b0;
         end
         if (fifo_ovf) ovf_q <= 1'b1;
         irq_q <= ie_q && fifo_empty && (state == TX_IDLE);
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         UART_STATUS: begin
            rdata[ST_BUSY_BIT]  = busy;
            rdata[ST_FULL_BIT]  = fifo_full;
            rdata[ST_EMPTY_BIT] = fifo_empty;
            rdata[ST_OVF_BIT]   = ovf_q;
            rdata[ST_IE_BIT]    = ie_q;
         end
         UART_DIV: rdata[15:0] = div_q;
         default:  rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev: frames on uart_txd are decoded against
// an ideal 8N1 frame model and register/irq behaviour against expected values.
module tb_uart_tx_dev;

   logic        clk_in = 1'b0;
   logic        sys_rstn;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        uart_txd;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_dev #(
      .BAUD_DIV   (4),
      .FIFO_DEPTH (8)
   ) dut (
      .clk_in   (clk_in),
      .sys_rstn (sys_rstn),
      .addr     (addr),
      .we       (we),
      .wdata    (wdata),
      .rdata    (rdata),
      .uart_txd (uart_txd),
      .irq      (irq)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk_in);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk_in);
      #1;
      we = 1'b0;
   endtask

   // Ideal frame: start(0), 8 data bits LSB first, stop(1), each exactly d cycles.
   // wait_cyc counts high samples seen before the start bit (-1 on timeout).
   task automatic capture(input int d, output logic [7:0] data, output int wait_cyc,
                          output bit fmt_ok);
      logic [9:0] bits;
      logic       s;
      wait_cyc = 0;
      fmt_ok   = 1'b1;
      data     = '0;
      bits     = '0;
      @(negedge clk_in);
      while (uart_txd !== 1'b0 && wait_cyc < 2000) begin
         wait_cyc++;
         @(negedge clk_in);
      end
      if (wait_cyc >= 2000) begin
         wait_cyc = -1;
         fmt_ok   = 1'b0;
         return;
      end
      for (int j = 0; j < 10 * d; j++) begin
         if (j > 0) @(negedge clk_in);
         s = uart_txd;
         if (j % d == 0) bits[j / d] = s;
         else if (s !== bits[j / d]) fmt_ok = 1'b0;
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) fmt_ok = 1'b0;
      data = bits[8:1];
   endtask

   task automatic test_reset;
      logic [31:0] r;
      sys_rstn = 1'b0;
      we = 1'b0; addr = 2'd0; wdata = '0;
      repeat (3) @(negedge clk_in);
      n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
      sys_rstn = 1'b1;
      rd(2'd1, r);
      n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h want 00000004", r); end
      rd(2'd2, r);
      n_checks++; if (r !== 32'd4) begin n_fail++; $display("FAIL reset_div: got %h want 00000004", r); end
      rd(2'd0, r);
      n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL read_data_zero: got %h want 0", r); end
      rd(2'd3, r);
      n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL read_addr3_zero: got %h want 0", r); end
   endtask

   task automatic test_single;
      logic [31:0] r;
      logic [7:0]  b, g;
      int          w;
      bit          ok;
      for (int n = 0; n < 4; n++) begin
         b = (n == 0) ? 8'hA5 : 8'($urandom);
         repeat ($urandom_range(0, 5)) @(negedge clk_in);
         wr(2'd0, {24'd0, b});
         capture(4, g, w, ok);
         n_checks++; if (g !== b) begin n_fail++; $display("FAIL single_data: got %h want %h", g, b); end
         n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_format: byte %h frame shape wrong", b); end
         n_checks++; if (w !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", w); end
         @(negedge clk_in);
         rd(2'd1, r);
         n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL single_idle_status: got %h want 00000004", r); end
      end
   endtask

   task automatic test_burst;
      logic [31:0] r;
      logic [7:0]  g;
      int          w, lows;
      bit          ok;
      wr(2'd2, 32'd2);
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk_in);
               if (i == 9) begin
                  rd(2'd1, r);
                  n_checks++; if (r !== 32'h3) begin n_fail++; $display("FAIL burst_full_no_ovf: got %h want 00000003", r); end
               end
               addr = 2'd0; wdata = i; we = 1'b1;
            end
            @(posedge clk_in);
            #1;
            we = 1'b0;
            rd(2'd1, r);
            n_checks++; if (r !== 32'hB) begin n_fail++; $display("FAIL burst_ovf_set: got %h want 0000000b", r); end
            wr(2'd1, 32'h8);
            rd(2'd1, r);
            n_checks++; if (r !== 32'h3) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000003", r); end
         end
         begin
            for (int i = 0; i < 9; i++) begin
               capture(2, g, w, ok);
               n_checks++; if (g !== 8'(i)) begin n_fail++; $display("FAIL burst_data: got %h want %h", g, 8'(i)); end
               n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL burst_format: frame %0d shape wrong", i); end
               if (i > 0) begin
                  n_checks++; if (w !== 1) begin n_fail++; $display("FAIL burst_gap: frame %0d got %0d want 1", i, w); end
               end
            end
         end
      join
      lows = 0;
      repeat (40) begin
         @(negedge clk_in);
         if (uart_txd !== 1'b1) lows++;
      end
      n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL burst_dropped: got %0d low cycles want 0", lows); end
      rd(2'd1, r);
      n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL burst_end_status: got %h want 00000004", r); end
   endtask

   task automatic test_divisor;
      logic [31:0] r;
      logic [7:0]  a, b, g;
      int          w;
      bit          ok;
      wr(2'd2, 32'd1);
      rd(2'd2, r);
      n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL div_floor1: got %h want 00000002", r); end
      wr(2'd2, 32'd0);
      rd(2'd2, r);
      n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL div_floor0: got %h want 00000002", r); end
      wr(2'd2, 32'hABCD0007);
      rd(2'd2, r);
      n_checks++; if (r !== 32'd7) begin n_fail++; $display("FAIL div_upper: got %h want 00000007", r); end
      wr(2'd2, 32'd2);
      a = 8'($urandom);
      b = 8'($urandom);
      fork
         begin
            wr(2'd0, {24'd0, a});
            wr(2'd0, {24'd0, b});
            repeat (5) @(negedge clk_in);
            wr(2'd2, 32'd6);
            rd(2'd2, r);
            n_checks++; if (r !== 32'd6) begin n_fail++; $display("FAIL div_mid_write: got %h want 00000006", r); end
         end
         begin
            capture(2, g, w, ok);
            n_checks++; if (g !== a || ok !== 1'b1) begin n_fail++; $display("FAIL div_old_frame: got %h ok=%0d want %h ok=1", g, ok, a); end
            capture(6, g, w, ok);
            n_checks++; if (g !== b || ok !== 1'b1) begin n_fail++; $display("FAIL div_new_frame: got %h ok=%0d want %h ok=1", g, ok, b); end
            n_checks++; if (w !== 1) begin n_fail++; $display("FAIL div_gap: got %0d want 1", w); end
         end
      join
   endtask

   task automatic test_irq;
      logic [31:0] r;
      logic [7:0]  b, g;
      int          w, hi;
      bit          ok;
      wr(2'd1, 32'h10);
      @(negedge clk_in);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag: got %b want 0", irq); end
      @(negedge clk_in);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq); end
      b = 8'($urandom);
      wr(2'd0, {24'd0, b});
      hi = 0;
      fork
         capture(6, g, w, ok);
         begin
            @(negedge clk_in);
            n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b want 1", irq); end
            repeat (20) begin
               @(negedge clk_in);
               if (irq !== 1'b0) hi++;
            end
         end
      join
      n_checks++; if (hi !== 0) begin n_fail++; $display("FAIL irq_busy: got %0d high cycles want 0", hi); end
      n_checks++; if (g !== b || ok !== 1'b1) begin n_fail++; $display("FAIL irq_frame: got %h ok=%0d want %h ok=1", g, ok, b); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_stop: got %b want 0", irq); end
      @(negedge clk_in);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle_lag: got %b want 0", irq); end
      @(negedge clk_in);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_drained: got %b want 1", irq); end
      wr(2'd1, 32'h18);
      rd(2'd1, r);
      n_checks++; if (r !== 32'h14) begin n_fail++; $display("FAIL ovf_clear_keep_ie: got %h want 00000014", r); end
      wr(2'd1, 32'h0);
      rd(2'd1, r);
      n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL ie_clear_status: got %h want 00000004", r); end
      repeat (2) @(negedge clk_in);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq); end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] r;
      logic [7:0]  b0;
      int          lows;
      wr(2'd2, 32'd4);
      b0 = 8'($urandom) & 8'hF7;
      wr(2'd0, {24'd0, b0});
      wr(2'd0, 32'($urandom));
      wr(2'd0, 32'($urandom));
      repeat (16) @(negedge clk_in);
      n_checks++; if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL rst_pre_bit3: got %b want 0", uart_txd); end
      sys_rstn = 1'b0;
      #1;
      n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL rst_txd_async: got %b want 1", uart_txd); end
      rd(2'd1, r);
      n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL rst_status: got %h want 00000004", r); end
      repeat (2) @(negedge clk_in);
      sys_rstn = 1'b1;
      lows = 0;
      repeat (60) begin
         @(negedge clk_in);
         if (uart_txd !== 1'b1) lows++;
      end
      n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL rst_no_frames: got %0d low cycles want 0", lows); end
      rd(2'd1, r);
      n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL rst_after_status: got %h want 00000004", r); end
      rd(2'd2, r);
      n_checks++; if (r !== 32'd4) begin n_fail++; $display("FAIL rst_after_div: got %h want 00000004", r); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_divisor();
      test_irq();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
